// File: rtl/instr_fetch_window_pkg.sv
// Shared definitions for the instruction fetch window: FSM states and
// helpers that derive column / program-counter widths from the bank geometry.
package instr_fetch_window_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_RUN   = 2'd1,
        S_WRITE = 2'd2
    } fetch_state_e;

    localparam int DEFAULT_NUM_BANKS = 8;
    localparam int DEFAULT_BANK_AW   = 12;

    function automatic int col_width(input int num_banks);
        return $clog2(num_banks);
    endfunction

    function automatic int pc_width(input int num_banks, input int bank_aw);
        return bank_aw + col_width(num_banks);
    endfunction

endpackage

// File: rtl/instr_fetch_window_bank_sram.sv
// Byte-wide single-port synchronous SRAM model (instr_bank_sram).
// One-cycle read latency; the read register holds its value when no read is issued.
module instr_bank_sram #(
    parameter int BANK_AW = 12
) (
    input  logic               clk,
    input  logic               ce_n,
    input  logic               we,
    input  logic               re,
    input  logic [BANK_AW-1:0] addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata
);

    localparam int BANK_DEPTH = 2 ** BANK_AW;

    logic [7:0] mem [BANK_DEPTH];

    always_ff @(posedge clk) begin
        if (!ce_n) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_window.sv
// Byte-interleaved instruction fetch window: presents NUM_BANKS consecutive
// bytes starting at pc, rotated so byte 0 of win_data is mem[pc].
module instr_fetch_window
    import instr_fetch_window_pkg::*;
#(
    parameter int NUM_BANKS = DEFAULT_NUM_BANKS,
    parameter int BANK_AW   = DEFAULT_BANK_AW,
    parameter int COL_W     = col_width(NUM_BANKS),
    parameter int PC_W      = BANK_AW + COL_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   adv_vld,
    input  logic [COL_W-1:0]       adv_len_m1,
    input  logic                   jump_en,
    input  logic [PC_W-1:0]        jump_addr,
    input  logic                   wr_vld,
    input  logic [BANK_AW-1:0]     wr_row,
    input  logic [8*NUM_BANKS-1:0] wr_data,
    input  logic [NUM_BANKS-1:0]   wr_be,
    output logic [8*NUM_BANKS-1:0] win_data,
    output logic                   win_vld,
    output logic [PC_W-1:0]        pc,
    input  logic [COL_W-1:0]       peek_sel,
    output logic [7:0]             peek_data
);

    fetch_state_e state, state_nxt;

    logic [PC_W-1:0]    next_pc;
    logic [COL_W-1:0]   nxt_col;
    logic [COL_W-1:0]   col_q;
    logic [BANK_AW-1:0] nxt_row;
    logic [BANK_AW-1:0] nxt_row_inc;
    logic [7:0]         bank_q [NUM_BANKS];

    always_comb begin
        state_nxt = state;
        next_pc   = pc;
        win_vld   = 1'b0;
        case (state)
            S_LOAD: begin
                state_nxt = wr_vld ? S_WRITE : S_RUN;
            end
            S_RUN: begin
                win_vld = 1'b1;
                // A concurrent loader write takes priority and drops the advance.
                if (wr_vld) begin
                    state_nxt = S_WRITE;
                end else if (adv_vld) begin
                    next_pc = jump_en ? jump_addr
                                      : pc + PC_W'(adv_len_m1) + PC_W'(1);
                end
            end
            S_WRITE: begin
                if (!wr_vld) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_LOAD;
            pc    <= '0;
            col_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= next_pc;
            col_q <= nxt_col;
        end
    end

    assign nxt_col     = next_pc[COL_W-1:0];
    assign nxt_row     = next_pc[PC_W-1:COL_W];
    assign nxt_row_inc = nxt_row + BANK_AW'(1);

    // Banks left of the start column hold the window's tail, one row further on.
    for (genvar j = 0; j < NUM_BANKS; j++) begin : g_bank
        localparam logic [COL_W-1:0] BANK_IDX = COL_W'(j);

        logic [BANK_AW-1:0] rd_row;
        logic [BANK_AW-1:0] bank_addr;

        assign rd_row    = (BANK_IDX < nxt_col) ? nxt_row_inc : nxt_row;
        assign bank_addr = wr_vld ? wr_row : rd_row;

        instr_bank_sram #(
            .BANK_AW (BANK_AW)
        ) u_bank (
            .clk   (clk),
            .ce_n  (rst),
            .we    (wr_vld & wr_be[j]),
            .re    (~wr_vld),
            .addr  (bank_addr),
            .wdata (wr_data[8*j +: 8]),
            .rdata (bank_q[j])
        );
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            win_data[8*k +: 8] = bank_q[col_q + COL_W'(k)];
        end
    end

    assign peek_data = bank_q[col_q + peek_sel];

endmodule

// File: tb/tb_instr_fetch_window.sv
// Scoreboard bench for instr_fetch_window: a byte-array reference model
// predicts every cycle's window; a negedge monitor compares.
module tb_instr_fetch_window;

    localparam int NB    = 8;
    localparam int AW    = 12;
    localparam int CW    = 3;
    localparam int PW    = 15;
    localparam int SPACE = 32768;

    logic            clk = 1'b0;
    logic            rst;
    logic            adv_vld;
    logic [CW-1:0]   adv_len_m1;
    logic            jump_en;
    logic [PW-1:0]   jump_addr;
    logic            wr_vld;
    logic [AW-1:0]   wr_row;
    logic [8*NB-1:0] wr_data;
    logic [NB-1:0]   wr_be;
    logic [8*NB-1:0] win_data;
    logic            win_vld;
    logic [PW-1:0]   pc;
    logic [CW-1:0]   peek_sel;
    logic [7:0]      peek_data;

    instr_fetch_window #(
        .NUM_BANKS (NB),
        .BANK_AW   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adv_vld    (adv_vld),
        .adv_len_m1 (adv_len_m1),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .wr_vld     (wr_vld),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .win_data   (win_data),
        .win_vld    (win_vld),
        .pc         (pc),
        .peek_sel   (peek_sel),
        .peek_data  (peek_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rst;
        bit          vld;
        logic [14:0] pc;
        logic [63:0] data;
        logic [7:0]  peek;
        bit          has_dir;
        string       dir_name;
        bit          dir_vld;
        logic [14:0] dir_pc;
        logic [63:0] dir_data;
    } sb_rec_t;

    sb_rec_t sb_q[$];

    logic [7:0] ref_mem [SPACE];
    int         ref_pc;
    int         blank;

    bit          pend_dir;
    string       pend_name;
    bit          pend_vld;
    logic [14:0] pend_pc;
    logic [63:0] pend_data;

    int errors = 0;
    int checks = 0;

    function automatic logic [63:0] ref_window(input int p);
        logic [63:0] w;
        for (int k = 0; k < NB; k++) begin
            w[8*k +: 8] = ref_mem[(p + k) % SPACE];
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expectDir(input string name, input bit vld, input logic [14:0] p, input logic [63:0] d);
        pend_dir  = 1'b1;
        pend_name = name;
        pend_vld  = vld;
        pend_pc   = p;
        pend_data = d;
    endtask

    // Push this cycle's prediction, clock once, then let the model absorb the inputs.
    task automatic applyStimulus();
        sb_rec_t r;
        bit      cur_vld;
        peek_sel   = CW'($urandom_range(0, NB - 1));
        cur_vld    = (blank == 0);
        r.is_rst   = 1'b0;
        r.vld      = cur_vld;
        r.pc       = 15'(ref_pc);
        r.data     = ref_window(ref_pc);
        r.peek     = r.data[int'(peek_sel)*8 +: 8];
        r.has_dir  = pend_dir;
        r.dir_name = pend_name;
        r.dir_vld  = pend_vld;
        r.dir_pc   = pend_pc;
        r.dir_data = pend_data;
        pend_dir   = 1'b0;
        sb_q.push_back(r);
        @(posedge clk);
        if (cur_vld && adv_vld && !wr_vld) begin
            ref_pc = jump_en ? int'(jump_addr) : (ref_pc + int'(adv_len_m1) + 1) % SPACE;
        end
        if (wr_vld) begin
            for (int j = 0; j < NB; j++) begin
                if (wr_be[j]) ref_mem[int'(wr_row)*NB + j] = wr_data[8*j +: 8];
            end
            blank = 2;
        end else if (blank > 0) begin
            blank--;
        end
        #1;
    endtask

    task automatic doReset();
        sb_rec_t r;
        rst        = 1'b1;
        r.is_rst   = 1'b1;
        r.vld      = 1'b0;
        r.pc       = '0;
        r.data     = '0;
        r.peek     = '0;
        r.has_dir  = 1'b0;
        r.dir_name = "";
        r.dir_vld  = 1'b0;
        r.dir_pc   = '0;
        r.dir_data = '0;
        sb_q.push_back(r);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ref_pc = 0;
        blank  = 1;
    endtask

    always @(negedge clk) begin
        sb_rec_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.is_rst) begin
                checkOutput("rst_pc", 64'(pc), 64'(e.pc));
                checkOutput("rst_win_vld", 64'(win_vld), 64'(e.vld));
            end else begin
                checkOutput("win_vld", 64'(win_vld), 64'(e.vld));
                if (e.vld) begin
                    checkOutput("pc", 64'(pc), 64'(e.pc));
                    checkOutput("win_data", win_data, e.data);
                    checkOutput("peek_data", 64'(peek_data), 64'(e.peek));
                end
                if (e.has_dir) begin
                    checkOutput({e.dir_name, "_pc"}, 64'(pc), 64'(e.dir_pc));
                    checkOutput({e.dir_name, "_vld"}, 64'(win_vld), 64'(e.dir_vld));
                    if (e.dir_vld) checkOutput({e.dir_name, "_data"}, win_data, e.dir_data);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        adv_vld    = 1'b0;
        adv_len_m1 = '0;
        jump_en    = 1'b0;
        jump_addr  = '0;
        wr_vld     = 1'b0;
        wr_row     = '0;
        wr_data    = '0;
        wr_be      = '0;
        peek_sel   = '0;
        pend_dir   = 1'b0;
        ref_pc     = 0;
        blank      = 1;
        @(posedge clk);
        #1;
        doReset();

        for (int r = 0; r < (1 << AW); r++) begin
            wr_vld = 1'b1;
            wr_row = AW'(r);
            wr_be  = 8'hFF;
            for (int j = 0; j < NB; j++) wr_data[8*j +: 8] = 8'(r*NB + j);
            applyStimulus();
        end
        wr_vld  = 1'b0;
        wr_be   = '0;
        wr_data = '0;
        applyStimulus();
        applyStimulus();

        expectDir("preload", 1'b1, 15'd0, 64'h0706050403020100);
        adv_vld = 1'b1; adv_len_m1 = 3'd2;
        applyStimulus();
        expectDir("seq3", 1'b1, 15'd3, 64'h0A09080706050403);
        adv_len_m1 = 3'd4;
        applyStimulus();
        expectDir("seq8", 1'b1, 15'd8, 64'h0F0E0D0C0B0A0908);
        adv_len_m1 = 3'd7;
        applyStimulus();
        expectDir("seq16", 1'b1, 15'd16, 64'h1716151413121110);
        adv_vld = 1'b0;
        applyStimulus();

        doReset();
        applyStimulus();
        expectDir("after_rst", 1'b1, 15'd0, 64'h0706050403020100);
        adv_vld = 1'b1; jump_en = 1'b1; jump_addr = 15'h7FFD;
        applyStimulus();

        expectDir("jump_wrap", 1'b1, 15'h7FFD, 64'h0403020100FFFEFD);
        jump_en = 1'b0; adv_len_m1 = 3'd0;
        wr_vld = 1'b1; wr_row = '0; wr_be = 8'h04; wr_data = 64'h0000000000AA0000;
        applyStimulus();
        wr_vld = 1'b0; wr_be = '0; wr_data = '0;
        expectDir("wr_drop", 1'b0, 15'h7FFD, 64'h0);
        applyStimulus();
        expectDir("adv_ignored", 1'b0, 15'h7FFD, 64'h0);
        applyStimulus();
        expectDir("refetch", 1'b1, 15'h7FFD, 64'h0403AA0100FFFEFD);
        jump_en = 1'b1; jump_addr = 15'h0000;
        applyStimulus();
        adv_vld = 1'b0; jump_en = 1'b0;
        expectDir("written", 1'b1, 15'd0, 64'h0706050403AA0100);
        applyStimulus();

        for (int i = 0; i < 3000; i++) begin
            adv_vld    = ($urandom_range(0, 3) != 0);
            adv_len_m1 = CW'($urandom_range(0, NB - 1));
            jump_en    = ($urandom_range(0, 7) == 0);
            jump_addr  = PW'($urandom());
            wr_vld     = ($urandom_range(0, 15) == 0);
            wr_row     = AW'($urandom());
            wr_data    = {$urandom(), $urandom()};
            wr_be      = NB'($urandom());
            applyStimulus();
        end
        adv_vld = 1'b0;
        wr_vld  = 1'b0;
        applyStimulus();
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
